// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Serial double-dabble binary-to-BCD converter (one bit/clock)
//               with sticky overflow and optional leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int WIDTH    = 27,
    parameter int DIGITS   = 8,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;
    logic               w_step;
    logic               w_finish;

    logic [WIDTH-1:0]   r_bin;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_sticky;
    logic               r_busy;
    logic               r_done;
    logic [ACC_W-1:0]   r_bcd;
    logic               r_overflow;

    logic [ACC_W-1:0]   w_acc_adj;
    logic [ACC_W-1:0]   w_bcd_disp;
    logic               w_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_step = 1'b1;
                if (r_count == c_last_step) begin
                    w_state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_finish     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Add-3 correction applied to every digit before each shift.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign w_acc_adj[4*k +: 4] = (r_acc[4*k +: 4] >= 4'd5) ?
                                     (r_acc[4*k +: 4] + 4'd3) : r_acc[4*k +: 4];
    end

    // Digits above the most significant non-zero digit become blank (F).
    always_comb begin
        w_seen     = 1'b0;
        w_bcd_disp = r_acc;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (r_acc[4*k +: 4] != 4'd0) begin
                w_seen = 1'b1;
            end
            if (BLANK_LZ && !w_seen) begin
                w_bcd_disp[4*k +: 4] = 4'hF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin      <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_sticky   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '1;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_bin    <= bin;
                r_acc    <= '0;
                r_count  <= '0;
                r_sticky <= 1'b0;
                r_busy   <= 1'b1;
            end
            if (w_step) begin
                r_acc   <= {w_acc_adj[ACC_W-2:0], r_bin[WIDTH-1]};
                r_bin   <= {r_bin[WIDTH-2:0], 1'b0};
                r_count <= r_count + CNT_W'(1);
                // A carry out of the top digit means the value needs one more digit.
                if (w_acc_adj[ACC_W-1]) begin
                    r_sticky <= 1'b1;
                end
            end
            if (w_finish) begin
                r_overflow <= r_sticky;
                r_bcd      <= r_sticky ? {ACC_W{1'b1}} : w_bcd_disp;
                r_done     <= 1'b1;
                r_busy     <= 1'b0;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_seq
// Description : Directed and random checks of bin_to_bcd_seq (blanked and
//               unblanked builds driven in parallel).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [26:0] bin;
    logic        busy, done, overflow;
    logic [31:0] bcd;
    logic        busy_nb, done_nb, overflow_nb;
    logic [31:0] bcd_nb;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(27), .DIGITS(8), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
    );

    bin_to_bcd_seq #(.WIDTH(27), .DIGITS(8), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy_nb), .done(done_nb), .bcd(bcd_nb), .overflow(overflow_nb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_bcd(input int unsigned v, input bit blank);
        logic [31:0] r;
        int unsigned t;
        if (v > 32'd99999999) return 32'hFFFFFFFF;
        t = v;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        if (blank) begin
            for (int k = 7; k >= 1; k--) begin
                if (r[4*k +: 4] != 4'd0) break;
                r[4*k +: 4] = 4'hF;
            end
        end
        return r;
    endfunction

    function automatic logic has_bad_code(input logic [31:0] b);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (b[4*k +: 4] >= 4'hA && b[4*k +: 4] <= 4'hE) bad = 1'b1;
        end
        return bad;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic do_conv(input logic [26:0] v, input logic [31:0] exp_bcd,
                           input logic exp_ovf, input logic [31:0] exp_nb, input string tag);
        int edges, busy_cnt;
        logic got;
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        bin      = 27'h5A5A5A5;
        busy_cnt = busy ? 1 : 0;
        edges    = 0;
        got      = 1'b0;
        while (edges < 100 && !got) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(edges), 32'd28);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd28);
        check({tag, "_bcd"}, bcd, exp_bcd);
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, "_bcd_nb"}, bcd_nb, exp_nb);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_bcd_hold"}, bcd, exp_bcd);
    endtask

    initial begin
        int nd, d1, d2;
        logic [31:0] dbcd;
        int unsigned rv;
        logic [31:0] eb, enb;

        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        check("reset_bcd", bcd, 32'hFFFFFFFF);
        rst = 1'b0;
        @(negedge clk);

        do_conv(27'd12345678,  32'h12345678, 1'b0, 32'h12345678, "v12345678");
        do_conv(27'd0,         32'hFFFFFFF0, 1'b0, 32'h00000000, "v0");
        do_conv(27'd305,       32'hFFFFF305, 1'b0, 32'h00000305, "v305");
        do_conv(27'd99999999,  32'h99999999, 1'b0, 32'h99999999, "v99999999");
        do_conv(27'd100000000, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, "v100000000");
        do_conv(27'd134217727, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, "vmax");
        do_conv(27'd9,         32'hFFFFFFF9, 1'b0, 32'h00000009, "v9");
        do_conv(27'd10000000,  32'h10000000, 1'b0, 32'h10000000, "v10000000");

        // Start while busy is ignored; bin changes mid-conversion have no effect.
        bin   = 27'd42;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        nd = 0; d1 = 0; dbcd = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 4) begin start = 1'b1; bin = 27'd7;  end
            if (i == 5) begin start = 1'b0; bin = 27'd99; end
            if (done) begin
                nd++;
                if (nd == 1) begin d1 = i; dbcd = bcd; end
            end
        end
        check("hs_done_count", 32'(nd), 32'd1);
        check("hs_latency", 32'(d1), 32'd28);
        check("hs_bcd", dbcd, 32'hFFFFFF42);

        // Start held through the done cycle restarts immediately.
        bin   = 27'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nd = 0; d1 = 0; d2 = 0; dbcd = '0;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (d1 != 0 && i == d1 + 1) start = 1'b0;
            if (done) begin
                nd++;
                if (nd == 1) d1 = i;
                if (nd == 2) begin d2 = i; dbcd = bcd; end
            end
        end
        start = 1'b0;
        check("b2b_done_count", 32'(nd), 32'd2);
        check("b2b_first", 32'(d1), 32'd28);
        check("b2b_interval", 32'(d2 - d1), 32'd29);
        check("b2b_bcd", dbcd, 32'hFFFFFFF7);

        // Reset in the middle of a conversion discards it.
        bin   = 27'd555;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", bcd, 32'hFFFFFFFF);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        nd = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) nd++;
        end
        check("rst_no_done", 32'(nd), 32'd0);
        do_conv(27'd555, 32'hFFFFF555, 1'b0, 32'h00000555, "after_rst");

        // Random regression against a division-based reference.
        for (int n = 0; n < 1000; n++) begin
            rv = $urandom_range(32'd134217727, 32'd0);
            if (n % 4 == 0) rv = $urandom_range(32'd100000100, 32'd99999900);
            eb  = ref_bcd(rv, 1'b1);
            enb = ref_bcd(rv, 1'b0);
            repeat ($urandom_range(3, 0)) @(negedge clk);
            do_conv(27'(rv), eb, (rv > 32'd99999999), enb, "rand");
            check("rand_digit_codes", 32'(has_bad_code(bcd)), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
